// File: rtl/irq_sequencer.sv
// Interrupt/exception entry controller for the 5-stage pipeline.
// Latches a user-mode timer IRQ or an illegal-opcode fault seen in ID.
// For an IRQ it waits for a safe ID-stage point, with a bounded wait.
// It then issues a one-cycle redirect with pipeline flushes and an EPC write.
// Further entries stay masked until the handler executes eret.
module irq_sequencer #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq_in,
    input  logic             illop_in,
    input  logic             id_valid,
    input  logic             id_kernel,
    input  logic             id_branch,
    input  logic             load_use_stall,
    input  logic             eret_in,
    output logic             redirect,
    output logic [2:0]       pcsrc_out,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             epc_we,
    output logic             epc_plus4,
    output logic             irq_ack,
    output logic             in_handler,
    output logic [CNT_W-1:0] irq_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_ENTER   = 2'd2;
    localparam logic [1:0] ST_HANDLER = 2'd3;

    localparam logic CAUSE_IRQ = 1'b0;
    localparam logic CAUSE_EXC = 1'b1;

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [1:0]        state_r, state_nx_s;
    logic              cause_r, cause_nx_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nx_s;
    logic [CNT_W-1:0]  irq_count_r, irq_count_nx_s;
    logic              safe_s;
    logic              exc_s;
    logic              user_irq_s;

    // Qualify incoming requests: only user-mode instructions can trap.
    always_comb begin
        safe_s     = id_valid & ~id_branch & ~load_use_stall;
        exc_s      = illop_in & id_valid & ~id_kernel;
        user_irq_s = irq_in & ~id_kernel;
    end

    // Next-state, cause and wait-counter selection.
    always_comb begin
        state_nx_s    = state_r;
        cause_nx_s    = cause_r;
        wait_cnt_nx_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (exc_s) begin
                    // The faulting instruction is itself in ID, so no safe point is needed.
                    cause_nx_s = CAUSE_EXC;
                    state_nx_s = ST_ENTER;
                end else if (user_irq_s) begin
                    cause_nx_s    = CAUSE_IRQ;
                    wait_cnt_nx_s = {WAIT_W{1'b0}};
                    state_nx_s    = ST_WAIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (exc_s) begin
                    cause_nx_s = CAUSE_EXC;
                    state_nx_s = ST_ENTER;
                end else if (safe_s) begin
                    state_nx_s = ST_ENTER;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    // Bounded latency: force entry even without a safe point.
                    state_nx_s = ST_ENTER;
                end else begin
                    wait_cnt_nx_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            ST_ENTER: begin
                state_nx_s = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (eret_in) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HANDLER;
                end
            end
            default: begin
                state_nx_s    = ST_IDLE;
                cause_nx_s    = CAUSE_IRQ;
                wait_cnt_nx_s = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Statistics counter: one increment per taken interrupt, wrapping naturally.
    always_comb begin
        if ((state_r == ST_ENTER) && (cause_r == CAUSE_IRQ)) begin
            irq_count_nx_s = irq_count_r + CNT_W'(1);
        end else begin
            irq_count_nx_s = irq_count_r;
        end
    end

    // State registers with synchronous reset; reset drops any pending entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cause_r     <= CAUSE_IRQ;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            irq_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            cause_r     <= cause_nx_s;
            wait_cnt_r  <= wait_cnt_nx_s;
            irq_count_r <= irq_count_nx_s;
        end
    end

    // Output decode from registered state and cause only, so no input-to-output paths.
    always_comb begin
        redirect   = 1'b0;
        pcsrc_out  = 3'b000;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        epc_we     = 1'b0;
        epc_plus4  = 1'b0;
        irq_ack    = 1'b0;
        in_handler = (state_r == ST_HANDLER);
        if (state_r == ST_ENTER) begin
            redirect   = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            epc_we     = 1'b1;
            if (cause_r == CAUSE_EXC) begin
                // The fault is not re-executed, so EPC points past it.
                pcsrc_out = 3'b101;
                epc_plus4 = 1'b1;
                irq_ack   = 1'b0;
            end else begin
                // The interrupted instruction is re-executed on return.
                pcsrc_out = 3'b100;
                epc_plus4 = 1'b0;
                irq_ack   = 1'b1;
            end
        end else begin
            redirect = 1'b0;
        end
    end

    assign irq_count = irq_count_r;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed testbench for irq_sequencer using hand-computed expected values.
module tb_irq_sequencer;

    logic       clk;
    logic       reset;
    logic       irq_in;
    logic       illop_in;
    logic       id_valid;
    logic       id_kernel;
    logic       id_branch;
    logic       load_use_stall;
    logic       eret_in;
    logic       redirect;
    logic [2:0] pcsrc_out;
    logic       flush_ifid;
    logic       flush_idex;
    logic       epc_we;
    logic       epc_plus4;
    logic       irq_ack;
    logic       in_handler;
    logic [7:0] irq_count;

    int total_checks;
    int passed_checks;

    // Packed view: {redirect, pcsrc, flush_ifid, flush_idex, epc_we, epc_plus4, irq_ack, in_handler}
    localparam logic [9:0] OUT_IDLE    = 10'b0_000_0_0_0_0_0_0;
    localparam logic [9:0] OUT_ENT_IRQ = 10'b1_100_1_1_1_0_1_0;
    localparam logic [9:0] OUT_ENT_EXC = 10'b1_101_1_1_1_1_0_0;
    localparam logic [9:0] OUT_HANDLER = 10'b0_000_0_0_0_0_0_1;

    logic [9:0] outs;
    assign outs = {redirect, pcsrc_out, flush_ifid, flush_idex, epc_we, epc_plus4, irq_ack, in_handler};

    irq_sequencer #(.MAX_WAIT(8), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .irq_in         (irq_in),
        .illop_in       (illop_in),
        .id_valid       (id_valid),
        .id_kernel      (id_kernel),
        .id_branch      (id_branch),
        .load_use_stall (load_use_stall),
        .eret_in        (eret_in),
        .redirect       (redirect),
        .pcsrc_out      (pcsrc_out),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .epc_we         (epc_we),
        .epc_plus4      (epc_plus4),
        .irq_ack        (irq_ack),
        .in_handler     (in_handler),
        .irq_count      (irq_count)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end else begin
            passed_checks++;
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // IRQ entry with a safe ID point; leaves the DUT in HANDLER.
    task automatic enter_irq();
        irq_in = 1'b1;
        step();
        step();
        irq_in = 1'b0;
        step();
    endtask

    task automatic do_eret();
        eret_in = 1'b1;
        step();
        eret_in = 1'b0;
    endtask

    initial begin
        total_checks   = 0;
        passed_checks  = 0;
        reset          = 1'b1;
        irq_in         = 1'b0;
        illop_in       = 1'b0;
        id_valid       = 1'b0;
        id_kernel      = 1'b0;
        id_branch      = 1'b0;
        load_use_stall = 1'b0;
        eret_in        = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_eq("reset_outs", 32'(outs), 32'(OUT_IDLE));
        check_eq("reset_count", 32'(irq_count), 32'd0);

        // 1: safe IRQ -> WAIT_SAFE, then ENTER, then HANDLER
        id_valid = 1'b1;
        irq_in   = 1'b1;
        step();
        check_eq("irq_wait_outs", 32'(outs), 32'(OUT_IDLE));
        step();
        check_eq("irq_enter_outs", 32'(outs), 32'(OUT_ENT_IRQ));
        irq_in = 1'b0;
        step();
        check_eq("irq_handler_outs", 32'(outs), 32'(OUT_HANDLER));
        check_eq("irq_count_1", 32'(irq_count), 32'd1);

        // 4: requests ignored in HANDLER; eret with IRQ high re-enters
        irq_in   = 1'b1;
        illop_in = 1'b1;
        step();
        check_eq("hdl_mask_1", 32'(outs), 32'(OUT_HANDLER));
        step();
        check_eq("hdl_mask_2", 32'(outs), 32'(OUT_HANDLER));
        illop_in = 1'b0;
        eret_in  = 1'b1;
        step();
        eret_in = 1'b0;
        check_eq("eret_idle", 32'(outs), 32'(OUT_IDLE));
        step();
        check_eq("reenter_wait", 32'(outs), 32'(OUT_IDLE));
        step();
        check_eq("reenter_enter", 32'(outs), 32'(OUT_ENT_IRQ));
        irq_in = 1'b0;
        step();
        check_eq("irq_count_2", 32'(irq_count), 32'd2);
        do_eret();
        check_eq("idle_after_2", 32'(outs), 32'(OUT_IDLE));

        // 2: illop with IRQ -> exception wins, one-cycle latency
        irq_in   = 1'b1;
        illop_in = 1'b1;
        step();
        check_eq("exc_enter_outs", 32'(outs), 32'(OUT_ENT_EXC));
        irq_in   = 1'b0;
        illop_in = 1'b0;
        step();
        check_eq("exc_handler_outs", 32'(outs), 32'(OUT_HANDLER));
        check_eq("exc_count_same", 32'(irq_count), 32'd2);
        do_eret();

        // 3a: branch held -> forced entry after 8 WAIT_SAFE cycles; IRQ drops while waiting
        irq_in    = 1'b1;
        id_branch = 1'b1;
        step();
        irq_in = 1'b0;
        for (int i = 1; i < 8; i++) begin
            check_eq($sformatf("forced_wait_%0d", i), 32'(outs), 32'(OUT_IDLE));
            step();
        end
        check_eq("forced_wait_8", 32'(outs), 32'(OUT_IDLE));
        step();
        check_eq("forced_enter", 32'(outs), 32'(OUT_ENT_IRQ));
        step();
        check_eq("irq_count_3", 32'(irq_count), 32'd3);
        id_branch = 1'b0;
        do_eret();

        // 3b: stall drops in the third WAIT_SAFE cycle -> ENTER in the fourth
        irq_in         = 1'b1;
        load_use_stall = 1'b1;
        step();
        irq_in = 1'b0;
        step();
        check_eq("stall_wait_2", 32'(outs), 32'(OUT_IDLE));
        step();
        load_use_stall = 1'b0;
        check_eq("stall_wait_3", 32'(outs), 32'(OUT_IDLE));
        step();
        check_eq("stall_enter_4", 32'(outs), 32'(OUT_ENT_IRQ));
        step();
        check_eq("irq_count_4", 32'(irq_count), 32'd4);
        do_eret();

        // 5: kernel mode ignores IRQ and illop
        id_kernel = 1'b1;
        irq_in    = 1'b1;
        illop_in  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq($sformatf("kernel_ignore_%0d", i), 32'(outs), 32'(OUT_IDLE));
        end
        check_eq("kernel_count", 32'(irq_count), 32'd4);
        id_kernel = 1'b0;
        irq_in    = 1'b0;
        illop_in  = 1'b0;
        step();

        // 6a: reset during WAIT_SAFE drops the pending entry
        irq_in    = 1'b1;
        id_branch = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset     = 1'b0;
        irq_in    = 1'b0;
        id_branch = 1'b0;
        check_eq("rst_wait_outs", 32'(outs), 32'(OUT_IDLE));
        check_eq("rst_wait_count", 32'(irq_count), 32'd0);
        step();
        check_eq("rst_wait_no_pend", 32'(outs), 32'(OUT_IDLE));
        step();
        check_eq("rst_wait_no_pend2", 32'(outs), 32'(OUT_IDLE));

        // 6b: reach 255 and reset in HANDLER
        for (int i = 0; i < 254; i++) begin
            enter_irq();
            do_eret();
        end
        enter_irq();
        check_eq("count_255", 32'(irq_count), 32'd255);
        check_eq("hdl_at_255", 32'(outs), 32'(OUT_HANDLER));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rst_hdl_outs", 32'(outs), 32'(OUT_IDLE));
        check_eq("rst_hdl_count", 32'(irq_count), 32'd0);

        // 6c: 256 entries from 0 wrap the counter to 0
        for (int i = 0; i < 255; i++) begin
            enter_irq();
            do_eret();
        end
        check_eq("wrap_pre_255", 32'(irq_count), 32'd255);
        enter_irq();
        check_eq("wrap_to_0", 32'(irq_count), 32'd0);
        do_eret();
        check_eq("wrap_idle", 32'(outs), 32'(OUT_IDLE));

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
